// File: rtl/obi_slave_arbiter_pkg.sv
// OBI address-phase and response channel types shared by obi_slave_arbiter and its users.
package obi_slave_arbiter_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_slave_arbiter.sv
// Round-robin arbiter sharing one OBI slave between NUM_MASTERS masters, with an in-order ID FIFO
// routing responses back. Define OBI_SLAVE_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module obi_slave_arbiter
    import obi_slave_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  obi_req_t  [NUM_MASTERS-1:0] master_req_i,
    output obi_resp_t [NUM_MASTERS-1:0] master_resp_o,
    output obi_req_t                    slave_req_o,
    input  obi_resp_t                   slave_resp_i
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [IW:0]   NM      = (IW + 1)'(NUM_MASTERS);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_P  = PW'(MAX_OUTSTANDING - 1);

    logic [IW-1:0] r_rr_ptr;
    logic          r_lock_q;
    logic [IW-1:0] r_lock_idx_q;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [IW-1:0] r_fifo [MAX_OUTSTANDING];

    logic          w_scan_valid;
    logic [IW-1:0] w_scan_idx;
    logic [IW:0]   w_idx;
    logic [IW-1:0] w_sel;
    logic          w_sel_valid;
    logic          w_can_issue;
    logic          w_issue;
    logic          w_hs;
    logic          w_stall;
    logic          w_push;
    logic          w_pop;
    logic [IW-1:0] w_head;

    // First requester at or above the round-robin pointer, wrapping around.
    always_comb begin
        w_scan_valid = 1'b0;
        w_scan_idx   = '0;
        w_idx        = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IW + 1)'(k);
            if (w_idx >= NM) begin
                w_idx = w_idx - NM;
            end
            if (!w_scan_valid && master_req_i[w_idx[IW-1:0]].req) begin
                w_scan_valid = 1'b1;
                w_scan_idx   = w_idx[IW-1:0];
            end
        end
    end

    assign w_sel       = r_lock_q ? r_lock_idx_q : w_scan_idx;
    assign w_sel_valid = r_lock_q ? master_req_i[r_lock_idx_q].req : w_scan_valid;

    // A response retiring this cycle frees a slot for a new issue in the same cycle.
    assign w_pop       = slave_resp_i.rvalid && (r_cnt != '0);
    assign w_can_issue = (r_cnt < MAX_CNT) || w_pop;
    assign w_issue     = w_sel_valid && w_can_issue;
    assign w_hs        = w_issue && slave_resp_i.gnt;
    assign w_stall     = w_issue && !slave_resp_i.gnt;
    assign w_push      = w_hs;
    assign w_head      = r_fifo[r_rd_ptr];

    always_comb begin
        slave_req_o   = '0;
        master_resp_o = '0;
        if (w_sel_valid) begin
            slave_req_o     = master_req_i[w_sel];
            slave_req_o.req = w_can_issue;
        end
        if (w_hs) begin
            master_resp_o[w_sel].gnt = 1'b1;
        end
        if (w_pop) begin
            master_resp_o[w_head].rvalid = 1'b1;
            master_resp_o[w_head].rdata  = slave_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr     <= '0;
            r_lock_q     <= 1'b0;
            r_lock_idx_q <= '0;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= (r_wr_ptr == LAST_P) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_P) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            // Hold a stalled address phase; drop the lock if its master abandons the request.
            if (w_hs) begin
                r_lock_q <= 1'b0;
            end else if (w_stall) begin
                r_lock_q     <= 1'b1;
                r_lock_idx_q <= w_sel;
            end else if (r_lock_q && !master_req_i[r_lock_idx_q].req) begin
                r_lock_q <= 1'b0;
            end

`ifdef OBI_SLAVE_ARBITER_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`else
            if (w_hs) begin
                r_rr_ptr <= (w_sel == IW'(NUM_MASTERS - 1)) ? '0 : w_sel + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_obi_slave_arbiter.sv
// Scoreboard bench for obi_slave_arbiter: grants checked per cycle, responses checked against a queue.
module tb_obi_slave_arbiter;
    import obi_slave_arbiter_pkg::*;

    localparam int N = 4;
`ifdef OBI_SLAVE_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    obi_req_t  [N-1:0] mreq;
    obi_resp_t [N-1:0] mresp;
    obi_req_t          sreq;
    obi_resp_t         sresp;

    typedef struct {
        int          m;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [N-1:0] gv;
    logic [N-1:0] ev;
    obi_req_t    er;

    always #5 clk_i = ~clk_i;

    obi_slave_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .master_req_i  (mreq),
        .master_resp_o (mresp),
        .slave_req_o   (sreq),
        .slave_resp_i  (sresp)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        for (int m = 0; m < N; m++) mreq[m] = '0;
        sresp = '0;
    endtask

    function automatic obi_req_t mk(int m);
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = (m % 2 == 1);
        r.be    = 4'hF;
        r.addr  = 32'(m) * 32'h100 + 32'h4000;
        r.wdata = 32'hC0DE_0000 + 32'(m);
        return r;
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        idle();
        sb.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        #4;
        checks++;
        if (mresp !== '0) begin errors++; $display("FAIL reset_resp: got %h required 0", mresp); end
        checks++;
        if (sreq !== '0) begin errors++; $display("FAIL reset_sreq: got %h required 0", sreq); end
        tick();
        rst_ni = 1'b1;
        tick();
        #4;
        checks++;
        if (mresp !== '0) begin errors++; $display("FAIL post_reset_resp: got %h required 0", mresp); end
        tick();
    endtask

    task automatic test_single_master();
        do_reset();
        mreq[2].req = 1'b1; mreq[2].we = 1'b1; mreq[2].be = 4'hF;
        mreq[2].addr = 32'h0000_1000; mreq[2].wdata = 32'hDEAD_BEEF;
        sresp.gnt = 1'b1;
        er = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF};
        #4;
        checks++;
        if (sreq !== er) begin errors++; $display("FAIL single_sreq: got %h required %h", sreq, er); end
        for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
        checks++;
        if (gv !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b required 0100", gv); end
        sb.push_back('{2, 32'h0});
        tick();
        // all masters request: next winner must be master 3 (pointer moved past 2)
        for (int m = 0; m < N; m++) mreq[m] = mk(m);
        e = sb.pop_front();
        sresp.rvalid = 1'b1; sresp.rdata = e.d;
        #4;
        for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
        ev = FIXED ? 4'b0001 : 4'b1000;
        checks++;
        if (gv !== ev) begin errors++; $display("FAIL single_rr_next: got %b required %b", gv, ev); end
        for (int m = 0; m < N; m++) begin
            checks++;
            if (mresp[m].rvalid !== (m == e.m) || mresp[m].rdata !== ((m == e.m) ? e.d : 32'h0)) begin
                errors++;
                $display("FAIL single_rsp m%0d: got rvalid=%b rdata=%h required rvalid=%b rdata=%h",
                         m, mresp[m].rvalid, mresp[m].rdata, (m == e.m), (m == e.m) ? e.d : 32'h0);
            end
        end
        sb.push_back('{FIXED ? 0 : 3, 32'hA5A5_0003});
        tick();
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            sresp.rvalid = 1'b1; sresp.rdata = e.d;
            #4;
            for (int m = 0; m < N; m++) begin
                checks++;
                if (mresp[m].rvalid !== (m == e.m) || mresp[m].rdata !== ((m == e.m) ? e.d : 32'h0)) begin
                    errors++;
                    $display("FAIL single_drain m%0d: got rvalid=%b rdata=%h required rvalid=%b",
                             m, mresp[m].rvalid, mresp[m].rdata, (m == e.m));
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_round_robin();
        bit have;
        int g;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            for (int m = 0; m < N; m++) mreq[m] = (c < 6) ? mk(m) : '0;
            sresp.gnt = 1'b1;
            have = (sb.size() > 0);
            if (have) begin
                e = sb.pop_front();
                sresp.rvalid = 1'b1; sresp.rdata = e.d;
            end else begin
                sresp.rvalid = 1'b0; sresp.rdata = 32'h0;
            end
            #4;
            if (c < 6) begin
                g = FIXED ? 0 : c % N;
                for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
                ev = N'(1) << g;
                checks++;
                if (gv !== ev) begin errors++; $display("FAIL rr_gnt c%0d: got %b required %b", c, gv, ev); end
                er = mk(g);
                checks++;
                if (sreq.addr !== er.addr) begin
                    errors++; $display("FAIL rr_addr c%0d: got %h required %h", c, sreq.addr, er.addr);
                end
                sb.push_back('{g, 32'hBEEF_0000 + 32'(c)});
            end
            if (have) begin
                for (int m = 0; m < N; m++) begin
                    checks++;
                    if (mresp[m].rvalid !== (m == e.m) || mresp[m].rdata !== ((m == e.m) ? e.d : 32'h0)) begin
                        errors++;
                        $display("FAIL rr_rsp c%0d m%0d: got rvalid=%b rdata=%h required rvalid=%b rdata=%h",
                                 c, m, mresp[m].rvalid, mresp[m].rdata, (m == e.m), (m == e.m) ? e.d : 32'h0);
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        sresp.gnt = 1'b0;
        mreq[3] = mk(3);
        er = mk(3);
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) mreq[0] = mk(0);
            #4;
            checks++;
            if ({sreq.req, sreq.addr} !== {1'b1, er.addr}) begin
                errors++; $display("FAIL lock_addr c%0d: got req=%b addr=%h required req=1 addr=%h",
                                   c, sreq.req, sreq.addr, er.addr);
            end
            for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
            checks++;
            if (gv !== 4'b0000) begin errors++; $display("FAIL lock_nognt c%0d: got %b required 0000", c, gv); end
            tick();
        end
        sresp.gnt = 1'b1;
        #4;
        for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
        checks++;
        if (gv !== 4'b1000) begin errors++; $display("FAIL lock_release: got %b required 1000", gv); end
        sb.push_back('{3, 32'h0000_3333});
        tick();
        mreq[3] = '0;
        #4;
        for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
        checks++;
        if (gv !== 4'b0001) begin errors++; $display("FAIL lock_next: got %b required 0001", gv); end
        sb.push_back('{0, 32'h0000_1111});
        tick();
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            sresp.rvalid = 1'b1; sresp.rdata = e.d;
            #4;
            for (int m = 0; m < N; m++) begin
                checks++;
                if (mresp[m].rvalid !== (m == e.m) || mresp[m].rdata !== ((m == e.m) ? e.d : 32'h0)) begin
                    errors++;
                    $display("FAIL lock_rsp m%0d: got rvalid=%b rdata=%h required rvalid=%b",
                             m, mresp[m].rvalid, mresp[m].rdata, (m == e.m));
                end
            end
            tick();
        end
        // locked master abandons its request: nothing forwarded that cycle, lock gone the next
        do_reset();
        mreq[1] = mk(1);
        tick();
        mreq[1] = '0;
        mreq[2] = mk(2);
        #4;
        checks++;
        if (sreq !== '0) begin errors++; $display("FAIL lock_drop_sreq: got %h required 0", sreq); end
        tick();
        sresp.gnt = 1'b1;
        er = mk(2);
        #4;
        checks++;
        if ({sreq.req, sreq.addr} !== {1'b1, er.addr} || mresp[2].gnt !== 1'b1) begin
            errors++; $display("FAIL lock_drop_next: got req=%b addr=%h gnt2=%b required req=1 addr=%h gnt2=1",
                               sreq.req, sreq.addr, mresp[2].gnt, er.addr);
        end
        tick();
        idle();
        sresp.rvalid = 1'b1; sresp.rdata = 32'h0000_2222;
        #4;
        checks++;
        if (mresp[2].rvalid !== 1'b1 || mresp[2].rdata !== 32'h0000_2222) begin
            errors++; $display("FAIL lock_drop_rsp: got rvalid=%b rdata=%h required 1 00002222",
                               mresp[2].rvalid, mresp[2].rdata);
        end
        tick();
        idle();
    endtask

    task automatic test_fifo_full();
        do_reset();
        sresp.gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mreq[c] = mk(c);
            #4;
            for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
            ev = N'(1) << c;
            checks++;
            if (gv !== ev) begin errors++; $display("FAIL full_fill c%0d: got %b required %b", c, gv, ev); end
            sb.push_back('{c, 32'hF000_0000 + 32'(c)});
            tick();
            mreq[c] = '0;
        end
        mreq[2] = mk(2);
        #4;
        for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
        checks++;
        if (sreq.req !== 1'b0 || gv !== 4'b0000) begin
            errors++; $display("FAIL full_block: got req=%b gnt=%b required req=0 gnt=0000", sreq.req, gv);
        end
        tick();
        e = sb.pop_front();
        sresp.rvalid = 1'b1; sresp.rdata = e.d;
        #4;
        for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
        checks++;
        if (sreq.req !== 1'b1 || gv !== 4'b0100) begin
            errors++; $display("FAIL full_reissue: got req=%b gnt=%b required req=1 gnt=0100", sreq.req, gv);
        end
        for (int m = 0; m < N; m++) begin
            checks++;
            if (mresp[m].rvalid !== (m == e.m) || mresp[m].rdata !== ((m == e.m) ? e.d : 32'h0)) begin
                errors++;
                $display("FAIL full_rsp m%0d: got rvalid=%b rdata=%h required rvalid=%b",
                         m, mresp[m].rvalid, mresp[m].rdata, (m == e.m));
            end
        end
        sb.push_back('{2, 32'hF000_0002});
        tick();
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            sresp.rvalid = 1'b1; sresp.rdata = e.d;
            #4;
            for (int m = 0; m < N; m++) begin
                checks++;
                if (mresp[m].rvalid !== (m == e.m) || mresp[m].rdata !== ((m == e.m) ? e.d : 32'h0)) begin
                    errors++;
                    $display("FAIL full_drain m%0d: got rvalid=%b rdata=%h required rvalid=%b",
                             m, mresp[m].rvalid, mresp[m].rdata, (m == e.m));
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_spurious();
        do_reset();
        sresp.rvalid = 1'b1; sresp.rdata = 32'h55AA_55AA;
        #4;
        checks++;
        if (mresp !== '0) begin errors++; $display("FAIL spurious_rsp: got %h required 0", mresp); end
        tick();
        // both slots must still be free afterwards
        idle();
        sresp.gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mreq[c] = mk(c);
            #4;
            for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
            ev = N'(1) << c;
            checks++;
            if (gv !== ev) begin errors++; $display("FAIL spurious_cnt c%0d: got %b required %b", c, gv, ev); end
            tick();
            mreq[c] = '0;
        end
        idle();
        tick();
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        sresp.gnt = 1'b1;
        mreq[0] = mk(0); tick(); mreq[0] = '0;
        mreq[1] = mk(1); tick();
        idle();
        rst_ni = 1'b0;
        sb.delete();
        tick();
        rst_ni = 1'b1;
        tick();
        sresp.rvalid = 1'b1; sresp.rdata = 32'hDEAD_0001;
        #4;
        checks++;
        if (mresp !== '0) begin errors++; $display("FAIL late_rvalid: got %h required 0", mresp); end
        tick();
        idle();
        sresp.gnt = 1'b1;
        for (int m = 0; m < N; m++) mreq[m] = mk(m);
        for (int c = 0; c < 3; c++) begin
            #4;
            for (int m = 0; m < N; m++) gv[m] = mresp[m].gnt;
            ev = (c == 2) ? 4'b0000 : ((FIXED || c == 0) ? 4'b0001 : 4'b0010);
            checks++;
            if (gv !== ev) begin errors++; $display("FAIL reset_mid_gnt c%0d: got %b required %b", c, gv, ev); end
            tick();
        end
        idle();
        tick();
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_single_master();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
